// File: rtl/div_tc_pkg.sv
// Shared widths, constants, state encoding and saturation helper for the
// div_tc_32_16 sequential divider.
// Build option: define DIV_TC_SIGNED_EN for two's-complement operands;
// leave it undefined for an unsigned divider with identical latency.
package div_tc_pkg;

    localparam int DIVIDEND_W = 32;
    localparam int DIVISOR_W  = 16;
    localparam int ITER_N     = 16;
    localparam int CNT_W      = 5;

    localparam logic [CNT_W-1:0]     CNT_LAST  = CNT_W'(ITER_N - 1);

    localparam logic [DIVISOR_W-1:0] Q_DBZ     = 16'hFFFF;
    localparam logic [DIVISOR_W-1:0] Q_SAT_POS = 16'h7FFF;
    localparam logic [DIVISOR_W-1:0] Q_SAT_NEG = 16'h8000;
    localparam logic [DIVISOR_W-1:0] Q_SAT_UNS = 16'hFFFF;

`ifdef DIV_TC_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    // Saturated quotient reported when the true quotient does not fit.
    function automatic logic [DIVISOR_W-1:0] sat_quotient(input logic res_neg);
        if (!SIGNED_EN) return Q_SAT_UNS;
        return res_neg ? Q_SAT_NEG : Q_SAT_POS;
    endfunction

endpackage

// File: rtl/div_tc_32_16_if.sv
// Request/response handshake bundle of the div_tc_32_16 divider.
// master = operation producer / result consumer, slave = the divider.
interface div_tc_32_16_if;
    import div_tc_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [DIVIDEND_W-1:0] dividend;
    logic [DIVISOR_W-1:0]  divisor;
    logic                  out_valid;
    logic                  out_ready;
    logic [DIVISOR_W-1:0]  quotient;
    logic [DIVISOR_W-1:0]  remainder;
    logic                  div_by_zero;
    logic                  overflow;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero, overflow
    );

endinterface

// File: rtl/div_tc_step.sv
// One radix-2 restoring division iteration: shift the partial remainder,
// bring in the next dividend bit, trial-subtract the divisor magnitude.
module div_tc_step
    import div_tc_pkg::*;
(
    input  logic [DIVISOR_W:0]   rem_in,
    input  logic                 next_bit,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [DIVISOR_W:0]   rem_out,
    output logic                 q_bit
);

    logic [DIVISOR_W+1:0] shifted;
    logic [DIVISOR_W+1:0] trial;

    // Trial subtraction; the borrow bit decides whether the difference is kept.
    always_comb begin
        // NOTE: every output is assigned on every path through this block, so no latch is inferred.
        shifted = {rem_in, next_bit};
        trial   = shifted - {2'b00, divisor};
        q_bit   = ~trial[DIVISOR_W+1];
        rem_out = q_bit ? trial[DIVISOR_W:0] : shifted[DIVISOR_W:0];
    end

endmodule

// File: rtl/div_tc_32_16.sv
// Sequential 32/16 divider, one restoring iteration per clock behind
// valid/ready handshakes. Early exit for divide-by-zero and for quotients
// that cannot fit in 16 bits; otherwise 16 CALC cycles then a FIX cycle.
// Build option: DIV_TC_SIGNED_EN selects signed (defined) or unsigned operands.
module div_tc_32_16
    import div_tc_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    div_tc_32_16_if.slave  bus
);

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic [DIVISOR_W:0]     prem;
    logic [DIVISOR_W-1:0]   lo_sr;
    logic [DIVISOR_W-1:0]   q_sr;
    logic [DIVISOR_W-1:0]   div_mag;
    logic                   sign_a;
    logic                   sign_b;

    logic [DIVIDEND_W-1:0]  dvd_mag;
    logic [DIVISOR_W-1:0]   dsr_mag;
    logic                   in_sign_a;
    logic                   in_sign_b;
    logic                   pre_ovf;

    logic [DIVISOR_W:0]     step_rem;
    logic                   step_q;

    logic                   res_neg;
    logic [DIVISOR_W-1:0]   q_final;
    logic [DIVISOR_W-1:0]   r_final;
    logic                   post_ovf;

    // Operand signs and magnitudes at the accept edge (raw operands when unsigned).
    always_comb begin
        in_sign_a = SIGNED_EN & bus.dividend[DIVIDEND_W-1];
        in_sign_b = SIGNED_EN & bus.divisor[DIVISOR_W-1];
        dvd_mag   = in_sign_a ? -bus.dividend : bus.dividend;
        dsr_mag   = in_sign_b ? -bus.divisor  : bus.divisor;
        pre_ovf   = dvd_mag[DIVIDEND_W-1:DIVISOR_W] >= dsr_mag;
    end

    div_tc_step u_step (
        .rem_in   (prem),
        .next_bit (lo_sr[DIVISOR_W-1]),
        .divisor  (div_mag),
        .rem_out  (step_rem),
        .q_bit    (step_q)
    );

    // Sign restoration and the representability post-check used in FIX.
    always_comb begin
        res_neg  = sign_a ^ sign_b;
        q_final  = res_neg ? -q_sr : q_sr;
        r_final  = sign_a ? -prem[DIVISOR_W-1:0] : prem[DIVISOR_W-1:0];
        post_ovf = SIGNED_EN && q_sr[DIVISOR_W-1] && !(q_sr == Q_SAT_NEG && res_neg);
    end

    // Control FSM plus all datapath and output registers.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments everywhere here so every register sees pre-edge values.
        if (rst) begin
            state           <= IDLE;
            cnt             <= '0;
            prem            <= '0;
            lo_sr           <= '0;
            q_sr            <= '0;
            div_mag         <= '0;
            sign_a          <= 1'b0;
            sign_b          <= 1'b0;
            bus.in_ready    <= 1'b1;
            bus.out_valid   <= 1'b0;
            bus.quotient    <= '0;
            bus.remainder   <= '0;
            bus.div_by_zero <= 1'b0;
            bus.overflow    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid && bus.in_ready) begin
                        bus.in_ready <= 1'b0;
                        sign_a       <= in_sign_a;
                        sign_b       <= in_sign_b;
                        if (bus.divisor == '0) begin
                            bus.quotient    <= Q_DBZ;
                            bus.remainder   <= bus.dividend[DIVISOR_W-1:0];
                            bus.div_by_zero <= 1'b1;
                            bus.overflow    <= 1'b0;
                            bus.out_valid   <= 1'b1;
                            state           <= DONE;
                        end else if (pre_ovf) begin
                            bus.quotient    <= sat_quotient(in_sign_a ^ in_sign_b);
                            bus.remainder   <= '0;
                            bus.div_by_zero <= 1'b0;
                            bus.overflow    <= 1'b1;
                            bus.out_valid   <= 1'b1;
                            state           <= DONE;
                        end else begin
                            prem    <= {1'b0, dvd_mag[DIVIDEND_W-1:DIVISOR_W]};
                            lo_sr   <= dvd_mag[DIVISOR_W-1:0];
                            q_sr    <= '0;
                            div_mag <= dsr_mag;
                            cnt     <= '0;
                            state   <= CALC;
                        end
                    end
                end
                CALC: begin
                    prem  <= step_rem;
                    lo_sr <= {lo_sr[DIVISOR_W-2:0], 1'b0};
                    q_sr  <= {q_sr[DIVISOR_W-2:0], step_q};
                    cnt   <= cnt + 1'b1;
                    if (cnt == CNT_LAST) state <= FIX;
                end
                FIX: begin
                    if (post_ovf) begin
                        bus.quotient  <= sat_quotient(res_neg);
                        bus.remainder <= '0;
                        bus.overflow  <= 1'b1;
                    end else begin
                        bus.quotient  <= q_final;
                        bus.remainder <= r_final;
                        bus.overflow  <= 1'b0;
                    end
                    bus.div_by_zero <= 1'b0;
                    bus.out_valid   <= 1'b1;
                    state           <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
